// File: rtl/spike_rx_pkg.sv
// -----------------------------------------------------------------------------
// spike_rx_pkg
// Shared types and constants for the spike handshake receiver.
//   rx_state_t : handshake FSM states (IDLE / ACK / RELEASE)
//   TS_W       : width of the optional capture timestamp
//   rx_entry_t : FIFO entry layout for the default 8-bit data path
// Optional feature macro: SPIKE_RX_TIMESTAMP_EN adds a timestamp to every entry.
// -----------------------------------------------------------------------------
package spike_rx_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACK     = 2'd1,
      RELEASE = 2'd2
   } rx_state_t;

   localparam int TS_W           = 16;
   localparam int RX_DATA_W_DFLT = 8;

   // Reference entry layout for the default data width. The top module builds
   // its own copy of this layout from its DATA_W parameter, because a package
   // typedef cannot follow a module parameter.
   typedef struct packed {
`ifdef SPIKE_RX_TIMESTAMP_EN
      logic [TS_W-1:0]           ts;
`endif
      logic [RX_DATA_W_DFLT-1:0] data;
   } rx_entry_t;

endpackage

// File: rtl/bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-flop synchroniser for a single asynchronous level signal.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input level
//   q   : d after STAGES flops in the clk domain
// -----------------------------------------------------------------------------
module bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[STAGES-2:0], d};
      end
   end

   assign q = r_sync[STAGES-1];

endmodule

// File: rtl/spike_handshake_receiver.sv
// -----------------------------------------------------------------------------
// spike_handshake_receiver
// Receives four-phase return-to-zero spike tokens (req_in / ack_in with bundled
// data_in) from the asynchronous neuron controller, stores them in a small
// FIFO and presents them downstream through a first-word fall-through
// valid/ready interface. A full FIFO withholds ack_in, stalling the async
// pipeline.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   req_in       : four-phase request (asynchronous, synchronised internally)
//   data_in      : bundled data, stable while req_in is high and ack_in low
//   ack_in       : registered four-phase acknowledge back to the controller
//   out_valid    : FIFO non-empty
//   out_ready    : downstream ready
//   out_data     : head-of-FIFO data
//   fifo_count   : current occupancy
//   out_ts       : capture timestamp of the head entry (SPIKE_RX_TIMESTAMP_EN)
//   o_dbg_state  : current handshake FSM state, for observation only
// Optional feature macro: SPIKE_RX_TIMESTAMP_EN.
//
// Handshake semantics (downstream): a token transfers on every rising clk edge
// where out_valid && out_ready; out_valid never depends on out_ready, and
// out_ready while empty is ignored.
// -----------------------------------------------------------------------------
module spike_handshake_receiver
   import spike_rx_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       req_in,
   input  logic [DATA_W-1:0]          data_in,
   output logic                       ack_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [$clog2(DEPTH+1)-1:0] fifo_count,
`ifdef SPIKE_RX_TIMESTAMP_EN
   output logic [TS_W-1:0]            out_ts,
`endif
   output logic [1:0]                 o_dbg_state
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // Same layout as spike_rx_pkg::rx_entry_t, sized by this instance's DATA_W.
   typedef struct packed {
`ifdef SPIKE_RX_TIMESTAMP_EN
      logic [TS_W-1:0]   ts;
`endif
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   rx_state_t         r_state;
   logic              r_ack;

   logic              w_req_s;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   entry_t            w_wr_entry;

   // ---------------------------------------------------------------------------
   // Request synchroniser. data_in is deliberately not synchronised: it is only
   // sampled once req_s is high, by which time the bundled-data timing
   // guarantees it has been stable for several cycles.
   // ---------------------------------------------------------------------------
   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_req_sync (
      .clk (clk),
      .rst (rst),
      .d   (req_in),
      .q   (w_req_s)
   );

   // Full is taken from the registered count, so a pop in the same cycle never
   // frees a slot for a push until the following cycle.
   assign w_full = (r_count == CNT_W'(DEPTH));
   // Capture only on the IDLE->ACK transition: a req_s held high through ACK
   // can never produce a second push.
   assign w_push = (r_state == IDLE) && w_req_s && !w_full;
   assign w_pop  = (r_count != '0) && out_ready;

`ifdef SPIKE_RX_TIMESTAMP_EN
   logic [TS_W-1:0] r_ts_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ts_cnt <= '0;
      end else begin
         r_ts_cnt <= r_ts_cnt + TS_W'(1);
      end
   end

   always_comb begin
      w_wr_entry      = '0;
      w_wr_entry.data = data_in;
      w_wr_entry.ts   = r_ts_cnt;
   end

   assign out_ts = r_mem[r_rd_ptr].ts;
`else
   always_comb begin
      w_wr_entry      = '0;
      w_wr_entry.data = data_in;
   end
`endif

   // ---------------------------------------------------------------------------
   // Handshake FSM with registered acknowledge.
   // RELEASE forces at least one cycle of ack low before the next capture.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_push) begin
                  r_state <= ACK;
                  r_ack   <= 1'b1;
               end
            end
            ACK: begin
               if (!w_req_s) begin
                  r_state <= RELEASE;
                  r_ack   <= 1'b0;
               end
            end
            RELEASE: begin
               r_state <= IDLE;
               r_ack   <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_ack   <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FIFO storage. Contents are not cleared by reset: the count and pointers
   // are, which makes every old entry unreachable.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   // Pointers are log2(DEPTH) bits wide and wrap naturally (DEPTH is a power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign ack_in      = r_ack;
   assign out_valid   = (r_count != '0);
   assign out_data    = r_mem[r_rd_ptr].data;
   assign fifo_count  = r_count;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spike_handshake_receiver.sv
// -----------------------------------------------------------------------------
// tb_spike_handshake_receiver
// Directed bench for spike_handshake_receiver (DATA_W=8, DEPTH=4, SYNC_STAGES=2).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// either 1 unit after the edge (directed checks) or on the falling edge
// (pop monitor). Expected tokens are queued when a request is raised and
// checked when the DUT hands them downstream.
// -----------------------------------------------------------------------------
module tb_spike_handshake_receiver;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 4;
   localparam int SYNC   = 2;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk;
   logic              rst;
   logic              req_in;
   logic [DATA_W-1:0] data_in;
   logic              ack_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]  fifo_count;
   logic [1:0]        dbg_state;
`ifdef SPIKE_RX_TIMESTAMP_EN
   logic [15:0]       out_ts;
   logic [15:0]       tb_ts;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic [DATA_W-1:0] exp_q[$];

   spike_handshake_receiver #(
      .DATA_W      (DATA_W),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_in      (req_in),
      .data_in     (data_in),
      .ack_in      (ack_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .fifo_count  (fifo_count),
`ifdef SPIKE_RX_TIMESTAMP_EN
      .out_ts      (out_ts),
`endif
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

`ifdef SPIKE_RX_TIMESTAMP_EN
   // Reference free-running timestamp.
   always @(posedge clk) begin
      if (rst) tb_ts <= 16'h0000;
      else     tb_ts <= tb_ts + 16'h0001;
   end
`endif

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
         end else begin
            chk("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for ack_in to reach a level; one comparison either way.
   task automatic wait_ack(input logic level, input int budget, input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (ack_in !== level && n < budget);
      chk(tag, 32'(ack_in), 32'(level));
   endtask

   // Full four-phase cycle for one token.
   task automatic send(input logic [DATA_W-1:0] d);
      data_in = d;
      req_in  = 1'b1;
      exp_q.push_back(d);
      wait_ack(1'b1, 12, "send_ack_rise");
      req_in = 1'b0;
      wait_ack(1'b0, 12, "send_ack_fall");
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      req_in    = 1'b0;
      data_in   = '0;
      out_ready = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_ack",   32'(ack_in),     32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      chk("rst_valid", 32'(out_valid),  32'd0);
      chk("rst_state", 32'(dbg_state),  32'd0);
      rst = 1'b0;
      repeat (2) tick();

      // Single token: ack must not appear before the request is synchronised,
      // and must be up four cycles after req_in rises.
      data_in = 8'hA5;
      req_in  = 1'b1;
      exp_q.push_back(8'hA5);
      repeat (SYNC) tick();
      chk("single_ack_early", 32'(ack_in), 32'd0);
      repeat (2) tick();
      chk("single_ack_lat",   32'(ack_in),     32'd1);
      chk("single_valid",     32'(out_valid),  32'd1);
      chk("single_data",      32'(out_data),   32'hA5);
      chk("single_count",     32'(fifo_count), 32'd1);
      req_in = 1'b0;
      repeat (3) tick();
      chk("single_ack_fall",  32'(ack_in), 32'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("single_drained", 32'(fifo_count), 32'd0);

      // Back-pressure: fifth request must be held while full.
      for (int i = 1; i <= 4; i++) send(8'(i));
      chk("bp_count4", 32'(fifo_count), 32'd4);
      data_in = 8'h05;
      req_in  = 1'b1;
      exp_q.push_back(8'h05);
      repeat (6) tick();
      chk("bp_ack_held",  32'(ack_in),     32'd0);
      chk("bp_count_hld", 32'(fifo_count), 32'd4);
      chk("bp_state",     32'(dbg_state),  32'd0);
      chk("bp_head",      32'(out_data),   32'h01);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      wait_ack(1'b1, 6, "bp_ack5");
      chk("bp_count_after", 32'(fifo_count), 32'd4);
      chk("bp_head2",       32'(out_data),   32'h02);
      req_in = 1'b0;
      wait_ack(1'b0, 12, "bp_ack5_fall");
      out_ready = 1'b1;
      repeat (6) tick();
      out_ready = 1'b0;
      chk("bp_drained", 32'(fifo_count),    32'd0);
      chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

      // Wrap-around and ordering with a always-ready consumer.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) send(8'(8'h10 + i));
      repeat (3) tick();
      chk("wrap_count",    32'(fifo_count),   32'd0);
      chk("wrap_sb_empty", 32'(exp_q.size()), 32'd0);
      out_ready = 1'b0;

      // Simultaneous push and pop at count 2.
      send(8'h20);
      send(8'h21);
      chk("sim_count2", 32'(fifo_count), 32'd2);
      data_in = 8'h22;
      req_in  = 1'b1;
      exp_q.push_back(8'h22);
      repeat (SYNC) tick();
      out_ready = 1'b1;   // pop lands on the capture edge
      tick();
      out_ready = 1'b0;
      chk("sim_count",  32'(fifo_count), 32'd2);
      chk("sim_head",   32'(out_data),   32'h21);
      chk("sim_ack",    32'(ack_in),     32'd1);
      req_in = 1'b0;
      wait_ack(1'b0, 12, "sim_ack_fall");
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("sim_drained", 32'(fifo_count), 32'd0);

      // Reset in the middle of a handshake with three entries held.
      send(8'h30);
      send(8'h31);
      data_in = 8'h32;
      req_in  = 1'b1;
      exp_q.push_back(8'h32);
      wait_ack(1'b1, 12, "mid_ack");
      chk("mid_count3", 32'(fifo_count), 32'd3);
      rst = 1'b1;
      tick();
      chk("mid_rst_ack",   32'(ack_in),     32'd0);
      chk("mid_rst_count", 32'(fifo_count), 32'd0);
      chk("mid_rst_valid", 32'(out_valid),  32'd0);
      chk("mid_rst_state", 32'(dbg_state),  32'd0);
      exp_q.delete();
      req_in = 1'b0;
      tick();
      rst = 1'b0;
      repeat (2) tick();
      send(8'h3C);
      chk("post_rst_count", 32'(fifo_count), 32'd1);
      chk("post_rst_data",  32'(out_data),   32'h3C);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("post_rst_drained", 32'(fifo_count), 32'd0);

`ifdef SPIKE_RX_TIMESTAMP_EN
      // Capture stamps just before and just after the counter wraps. A request
      // raised when the counter reads T is captured with stamp T+2.
      begin
         int guard;
         guard = 0;
         while (tb_ts != 16'hFFFC && guard < 70000) begin
            tick();
            guard++;
         end
         chk("ts_reach", 32'(tb_ts), 32'hFFFC);
         send(8'h40);
         chk("ts_first", 32'(out_ts), 32'hFFFE);
         guard = 0;
         while (tb_ts != 16'h0004 && guard < 70000) begin
            tick();
            guard++;
         end
         send(8'h41);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
         chk("ts_second",      32'(out_ts),   32'h0006);
         chk("ts_second_data", 32'(out_data), 32'h41);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end
`endif

      repeat (2) tick();
      chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
